// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths and the fetch FSM state indices, which
// the control-unit debug decode reuses to interpret dbg_state.
package cpu_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned MEM_DATA_W = 8;

    // Bit positions of each state inside the one-hot dbg_state vector.
    localparam int unsigned S_IDLE     = 0;
    localparam int unsigned S_REQ_LO   = 1;
    localparam int unsigned S_REQ_HI   = 2;
    localparam int unsigned S_DONE     = 3;
    localparam int unsigned NUM_STATES = 4;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE   = 4'(1 << S_IDLE),
        ST_REQ_LO = 4'(1 << S_REQ_LO),
        ST_REQ_HI = 4'(1 << S_REQ_HI),
        ST_DONE   = 4'(1 << S_DONE)
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk, rst        : clock, synchronous active-high reset (pc -> RESET_PC)
//   incr_i          : pc += one instruction (2 bytes), wraps mod 2^ADDR_W
//   load_i          : pc <= load_value_i, takes priority over incr_i
//   load_value_i    : branch/jump target
//   pc_o            : current program counter
module pc_reg
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              incr_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_value_i,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / MEM_DATA_W);

    logic [ADDR_W-1:0] pc_d, pc_q;

    // Next PC: load beats increment; addition wraps naturally at ADDR_W bits.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_value_i;
        end else if (incr_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder: on fetch_en reads a 16-bit instruction as two
// byte reads (lo at fa, hi at fa+1) and holds fetch_ready until fetch_en drops.
// Optional macro FETCH_BUFFER_EN adds a one-entry buffer that skips memory when
// the last completed fetch address equals pc.
//   clk, rst        : clock, synchronous active-high reset
//   fetch_en        : level fetch request from the control unit
//   incr_pc/pc_load : PC update pulses (load has priority), pc_load_value target
//   fetch_ready     : instr valid for the current request (level, registered)
//   instr           : fetched instruction {hi_byte, lo_byte}
//   pc              : current program counter
//   mem_rd/mem_addr : byte read request, held stable until mem_ack
//   mem_rdata/ack   : read data and completion from instruction memory
//   dbg_state       : one-hot FSM state {DONE, REQ_HI, REQ_LO, IDLE}
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  incr_pc,
    input  logic                  pc_load,
    input  logic [ADDR_W-1:0]     pc_load_value,
    output logic                  fetch_ready,
    output logic [INSTR_W-1:0]    instr,
    output logic [ADDR_W-1:0]     pc,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [3:0]            dbg_state
);

    fetch_state_e          state_q;
    logic [ADDR_W-1:0]     fa_q;
    logic [MEM_DATA_W-1:0] lo_q;
    logic [INSTR_W-1:0]    instr_q;
    logic                  fetch_ready_q;
    logic                  mem_rd_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic                  buf_hit_c;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .incr_i       (incr_pc),
        .load_i       (pc_load),
        .load_value_i (pc_load_value),
        .pc_o         (pc)
    );

`ifdef FETCH_BUFFER_EN
    logic              buf_valid_q;
    logic [ADDR_W-1:0] buf_addr_q;

    // Last completed fetch is still valid for this pc; pc_load is covered by the compare.
    assign buf_hit_c = buf_valid_q && (buf_addr_q == pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
        end else if (state_q == ST_REQ_HI && mem_ack && fetch_en) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= fa_q;
        end
    end
`else
    assign buf_hit_c = 1'b0;
`endif

    // Fetch FSM; memory strobes and fetch_ready are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fa_q          <= '0;
            lo_q          <= '0;
            instr_q       <= '0;
            fetch_ready_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_en) begin
                        fa_q <= pc;
                        if (buf_hit_c) begin
                            state_q       <= ST_DONE;
                            fetch_ready_q <= 1'b1;
                        end else begin
                            state_q    <= ST_REQ_LO;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= pc;
                        end
                    end
                end
                ST_REQ_LO: begin
                    // An aborted request still waits for its ack before leaving.
                    if (mem_ack) begin
                        lo_q <= mem_rdata;
                        if (fetch_en) begin
                            state_q    <= ST_REQ_HI;
                            mem_addr_q <= fa_q + ADDR_W'(1);
                        end else begin
                            state_q  <= ST_IDLE;
                            mem_rd_q <= 1'b0;
                        end
                    end
                end
                ST_REQ_HI: begin
                    if (mem_ack) begin
                        mem_rd_q <= 1'b0;
                        if (fetch_en) begin
                            state_q       <= ST_DONE;
                            instr_q       <= {mem_rdata, lo_q};
                            fetch_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!fetch_en) begin
                        state_q       <= ST_IDLE;
                        fetch_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    fetch_ready_q <= 1'b0;
                    mem_rd_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign instr       = instr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of fetch vectors, byte memory model with a
// programmable ack delay, and a scoreboard of expected read addresses.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        incr_pc;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        fetch_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:65535];
    int unsigned ack_delay = 0;
    int unsigned wait_cnt;
    logic [15:0] exp_q [$];
    logic        was_waiting = 1'b0;
    logic [15:0] held_addr = '0;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .incr_pc       (incr_pc),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .fetch_ready   (fetch_ready),
        .instr         (instr),
        .pc            (pc),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ack_delay waiting cycles (0 = same cycle as mem_rd).
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_rd && (wait_cnt == ack_delay);

    always @(posedge clk) begin
        if (rst || !mem_rd || mem_ack) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed read must match the next expected address,
    // and a waiting request must hold mem_rd/mem_addr.
    always @(negedge clk) begin
        logic [15:0] exp_a;
        if (!rst && mem_rd && mem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
            end else begin
                exp_a = exp_q.pop_front();
                check("read_addr", {16'h0, mem_addr}, {16'h0, exp_a});
            end
        end
        if (!rst && was_waiting) check("req_stable", {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, held_addr});
        was_waiting = !rst && mem_rd && !mem_ack;
        held_addr   = mem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_load = 1'b1;
        pc_load_value = v;
        tick();
        pc_load = 1'b0;
    endtask

    // One complete fetch: raise fetch_en, wait for fetch_ready, drop fetch_en.
    task automatic do_fetch(input string tag, input logic [15:0] addr, input bit uses_mem,
                            input logic [15:0] exp_instr, input int exp_lat, input bit bump);
        int n;
        logic [15:0] a1;
        a1 = addr + 16'd1;
        if (uses_mem) begin
            exp_q.push_back(addr);
            exp_q.push_back(a1);
        end
        fetch_en = 1'b1;
        n = 0;
        while (!fetch_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_instr"}, {16'h0, instr}, {16'h0, exp_instr});
        check({tag, "_state"}, {28'h0, dbg_state}, 32'h8);
        fetch_en = 1'b0;
        incr_pc  = bump;
        tick();
        incr_pc  = 1'b0;
        check({tag, "_ready_drop"}, {31'h0, fetch_ready}, 32'h0);
        check({tag, "_idle"}, {28'h0, dbg_state}, 32'h1);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int unsigned delay;
        logic [15:0] instr;
        int          lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw_ready;
        bit saw_hi;

        vecs[0] = '{16'h0000, 8'h34, 8'h12, 0, 16'h1234, 3};
        vecs[1] = '{16'h0100, 8'hCD, 8'hAB, 3, 16'hABCD, 9};
        vecs[2] = '{16'hFFFF, 8'h78, 8'h56, 1, 16'h5678, 5};
        vecs[3] = '{16'h1234, 8'hEF, 8'hBE, 2, 16'hBEEF, 7};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; fetch_en = 1'b0; incr_pc = 1'b0; pc_load = 1'b0; pc_load_value = '0;
        tick();
        tick();
        check("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_state", {28'h0, dbg_state}, 32'h1);
        rst = 1'b0;
        tick();

        // Table-driven fetches: varied addresses, data and ack delays.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a1;
            a1 = vecs[i].addr + 16'd1;
            mem[vecs[i].addr] = vecs[i].lo;
            mem[a1] = vecs[i].hi;
            ack_delay = vecs[i].delay;
            load_pc(vecs[i].addr);
            check($sformatf("vec%0d_pc", i), {16'h0, pc}, {16'h0, vecs[i].addr});
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, 1'b1, vecs[i].instr, vecs[i].lat, 1'b0);
            check($sformatf("vec%0d_pc_kept", i), {16'h0, pc}, {16'h0, vecs[i].addr});
        end

        // Abort during REQ_LO: read completes, no REQ_HI, no fetch_ready, instr kept.
        ack_delay = 3;
        mem[16'h0200] = 8'h11;
        load_pc(16'h0200);
        exp_q.push_back(16'h0200);
        fetch_en = 1'b1;
        tick();
        tick();
        fetch_en = 1'b0;
        saw_ready = 1'b0;
        saw_hi = 1'b0;
        n = 0;
        while (dbg_state != 4'h1 && n < 20) begin
            tick();
            n++;
            if (fetch_ready) saw_ready = 1'b1;
            if (dbg_state == 4'h4) saw_hi = 1'b1;
        end
        check("abort_idle", {28'h0, dbg_state}, 32'h1);
        check("abort_no_ready", {31'h0, saw_ready}, 32'h0);
        check("abort_no_hi", {31'h0, saw_hi}, 32'h0);
        check("abort_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("abort_read_done", exp_q.size(), 32'h0);
        check("abort_instr_kept", {16'h0, instr}, 32'h0000BEEF);

        // PC wrap and load-over-increment priority.
        load_pc(16'hFFFE);
        check("pc_load", {16'h0, pc}, 32'h0000FFFE);
        incr_pc = 1'b1;
        tick();
        incr_pc = 1'b0;
        check("pc_wrap", {16'h0, pc}, 32'h0);
        pc_load = 1'b1; incr_pc = 1'b1; pc_load_value = 16'h0100;
        tick();
        pc_load = 1'b0; incr_pc = 1'b0;
        check("pc_load_prio", {16'h0, pc}, 32'h00000100);
        incr_pc = 1'b1;
        tick();
        incr_pc = 1'b0;
        check("pc_incr", {16'h0, pc}, 32'h00000102);

        // Control-unit style loop: fetch, decode (incr_pc), alu, four instructions.
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            mem[2*i]   = 8'(8'h11 * i);
            mem[2*i+1] = 8'(8'hA0 + i);
        end
        load_pc(16'h0000);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            logic [15:0] e;
            a = 16'(2 * i);
            e = {8'(8'hA0 + i), 8'(8'h11 * i)};
            check($sformatf("loop%0d_pc", i), {16'h0, pc}, {16'h0, a});
            do_fetch($sformatf("loop%0d", i), a, 1'b1, e, 3, 1'b1);
            tick();
        end
        check("loop_pc_end", {16'h0, pc}, 32'h8);

`ifdef FETCH_BUFFER_EN
        // Buffer hit skips memory; reset invalidates the buffer.
        mem[16'h0010] = 8'h5A;
        mem[16'h0011] = 8'hA5;
        load_pc(16'h0010);
        do_fetch("buf_fill", 16'h0010, 1'b1, 16'hA55A, 3, 1'b0);
        load_pc(16'h0020);
        load_pc(16'h0010);
        do_fetch("buf_hit", 16'h0010, 1'b0, 16'hA55A, 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("buf_rst_pc", {16'h0, pc}, 32'h0);
        load_pc(16'h0010);
        do_fetch("buf_after_rst", 16'h0010, 1'b1, 16'hA55A, 3, 1'b0);
`endif

        tick();
        check("no_pending_reads", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
